keyboard_note_tracker: RTL and testbench
========================================

KEYBOARD_NOTE_TRACKER -- requirements
Module: keyboard_note_tracker

Interface
REQ-001 Parameter: PREFIX_TIMEOUT, default 1_000_000, clk cycles after an F0/E0 prefix before the prefix is abandoned.
REQ-002 clk  input  1  system clock, 100 MHz; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 byte_valid  input  1  one-cycle strobe; byte_data holds a complete PS/2 scancode byte.
REQ-005 byte_data  input  8  scancode byte from the PS/2 receiver stage.
REQ-006 all_off  input  1  synchronous panic clear; releases all keys.
REQ-007 key_mask  output  8  held-key bitmap: bit0=C4, bit1=D4, bit2=E4, bit3=F4, bit4=G4, bit5=A4, bit6=B4, bit7=C5; drives per-note sine enables.
REQ-008 note_period  output  20  half-period count of the active note for the square-wave divider; 0 = silence.
REQ-009 note_on  output  1  one-cycle pulse on an accepted make of a mapped key.
REQ-010 note_off  output  1  one-cycle pulse on an accepted break of a held mapped key.

Function
REQ-011 Scancode map: 1C=C4, 1B=D4, 23=E4, 2B=F4, 34=G4, 33=A4, 3B=B4, 42=C5; all other codes are unmapped.
REQ-012 Periods: C4 191109, D4 170265, E4 151685, F4 143172, G4 127550, A4 113636, B4 101238, C5 95556.
REQ-013 Decoder FSM states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0).
REQ-014 IDLE: F0 -> BRK; E0 -> EXT; mapped code -> make event, stay IDLE; unmapped -> no effect, stay IDLE.
REQ-015 BRK: any byte -> IDLE; mapped code -> break event.
REQ-016 EXT: F0 -> EXT_BRK; any other byte -> IDLE, discarded. EXT_BRK: any byte -> IDLE, discarded (extended keys never play).
REQ-017 Prefix timer: cleared on every accepted byte; in BRK/EXT/EXT_BRK, after PREFIX_TIMEOUT cycles with no byte_valid -> IDLE, no event.
REQ-018 Make event: set key bit; record key as last_key; pulse note_on.
REQ-019 Break event: clear key bit; pulse note_off only if the bit was set; break of a key not held -> no pulse, no change.
REQ-020 note_period = period(last_key) while last_key is held; when last_key is released, last_key becomes the lowest-index held bit; no keys held -> 0.
REQ-021 Latency: key_mask, note_period, note_on, note_off update on the first clk edge after the byte_valid cycle; all outputs registered.
REQ-022 all_off asserted: key_mask=0, note_period=0, FSM=IDLE, timer cleared, no pulses; wins over a coincident byte_valid, which is discarded.
REQ-023 note_on and note_off never both assert in the same cycle.

Reset
REQ-024 rst low: key_mask=0, note_period=0, note_on=0, note_off=0, FSM=IDLE, timer=0, last_key=0; takes effect immediately without clk.
REQ-025 Reset deassertion mid-prefix: the prefix is lost; the next byte is decoded from IDLE.

Configuration
REQ-026 Macro KNT_TYPEMATIC_FILTER_EN defined: a make of an already-held key produces no note_on and does not change last_key.
REQ-027 Macro undefined: every make of a mapped key, held or not, pulses note_on and sets last_key.

Structure
REQ-028 Package note_pkg: scancode constants, 20-bit period constants, FSM state enum, key-index width.
REQ-029 Sub-module note_period_lut: combinational 3-bit index -> 20-bit period, shared with the music-box path.

Verification
REQ-030 Reset, then bytes 1C -> key_mask=01, note_period=191109, note_on pulse one cycle after byte_valid.
REQ-031 1C, 34, F0 34 -> mask 11 then 01; period 191109 -> 127550 -> 191109; one note_off pulse.
REQ-032 E0 1C, then E0 F0 1C -> key_mask, note_period, note_on and note_off all unchanged.
REQ-033 F0, then PREFIX_TIMEOUT+1 idle cycles, then 1B -> make D4 (mask 02, period 170265), not a break.
REQ-034 33 33 with KNT_TYPEMATIC_FILTER_EN -> one note_on; without the macro -> two note_on pulses.
REQ-035 Keys 1C 23 42 held, all_off coincident with byte F0 -> mask 00, period 0, no note_off pulse; next 1C -> make C4.

Source files
------------

// File: rtl/note_pkg.sv
// Shared definitions for the keyboard note tracker and the music-box path:
// PS/2 scancodes for the eight playable keys, their half-period counts,
// the scancode decoder state type and a couple of small helper functions.
package note_pkg;

    localparam int KEY_IDX_W = 3;
    localparam int NUM_KEYS  = 8;
    localparam int PERIOD_W  = 20;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_C4    = 8'h1C;
    localparam logic [7:0] SC_D4    = 8'h1B;
    localparam logic [7:0] SC_E4    = 8'h23;
    localparam logic [7:0] SC_F4    = 8'h2B;
    localparam logic [7:0] SC_G4    = 8'h34;
    localparam logic [7:0] SC_A4    = 8'h33;
    localparam logic [7:0] SC_B4    = 8'h3B;
    localparam logic [7:0] SC_C5    = 8'h42;

    localparam logic [PERIOD_W-1:0] PER_C4 = 20'd191109;
    localparam logic [PERIOD_W-1:0] PER_D4 = 20'd170265;
    localparam logic [PERIOD_W-1:0] PER_E4 = 20'd151685;
    localparam logic [PERIOD_W-1:0] PER_F4 = 20'd143172;
    localparam logic [PERIOD_W-1:0] PER_G4 = 20'd127550;
    localparam logic [PERIOD_W-1:0] PER_A4 = 20'd113636;
    localparam logic [PERIOD_W-1:0] PER_B4 = 20'd101238;
    localparam logic [PERIOD_W-1:0] PER_C5 = 20'd95556;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } dec_state_t;

    typedef struct packed {
        logic                 hit;
        logic [KEY_IDX_W-1:0] idx;
    } key_lookup_t;

    // Translate a scancode into a key index; hit is low for unmapped codes.
    function automatic key_lookup_t lookup_scancode(input logic [7:0] code);
        key_lookup_t r;
        r.hit = 1'b1;
        r.idx = '0;
        case (code)
            SC_C4:   r.idx = 3'd0;
            SC_D4:   r.idx = 3'd1;
            SC_E4:   r.idx = 3'd2;
            SC_F4:   r.idx = 3'd3;
            SC_G4:   r.idx = 3'd4;
            SC_A4:   r.idx = 3'd5;
            SC_B4:   r.idx = 3'd6;
            SC_C5:   r.idx = 3'd7;
            default: r.hit = 1'b0;
        endcase
        return r;
    endfunction

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [KEY_IDX_W-1:0] lowest_held(input logic [NUM_KEYS-1:0] mask);
        logic [KEY_IDX_W-1:0] r;
        r = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (mask[i]) r = KEY_IDX_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/note_period_lut.sv
// Combinational key index -> half-period lookup. Also used by the music-box
// path, so it stays a standalone module with no state.
module note_period_lut
    import note_pkg::*;
(
    input  logic [2:0]  i_key_idx,
    output logic [19:0] o_period
);

    // Pure table lookup, one entry per key of the octave.
    always_comb begin
        o_period = '0;
        case (i_key_idx)
            3'd0:    o_period = PER_C4;
            3'd1:    o_period = PER_D4;
            3'd2:    o_period = PER_E4;
            3'd3:    o_period = PER_F4;
            3'd4:    o_period = PER_G4;
            3'd5:    o_period = PER_A4;
            3'd6:    o_period = PER_B4;
            3'd7:    o_period = PER_C5;
            default: o_period = '0;
        endcase
    end

endmodule

// File: rtl/keyboard_note_tracker.sv
// Keyboard note tracker: decodes PS/2 make/break scancodes into a held-key
// bitmap plus the half-period of the most recently pressed held key.
// Optional macro KNT_TYPEMATIC_FILTER_EN suppresses note_on and last-key
// updates for repeated makes of a key that is already held.
module keyboard_note_tracker
    import note_pkg::*;
#(
    parameter int PREFIX_TIMEOUT = 1_000_000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte_data,
    input  logic        i_all_off,
    output logic [7:0]  o_key_mask,
    output logic [19:0] o_note_period,
    output logic        o_note_on,
    output logic        o_note_off
);

    localparam int TW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(PREFIX_TIMEOUT - 1);

    dec_state_t           r_state;
    dec_state_t           w_next_state;
    logic [TW-1:0]        r_timer;
    logic [NUM_KEYS-1:0]  r_key_mask;
    logic [KEY_IDX_W-1:0] r_last_key;
    logic [PERIOD_W-1:0]  r_note_period;
    logic                 r_note_on;
    logic                 r_note_off;

    key_lookup_t          w_lookup;
    logic                 w_make;
    logic                 w_break;
    logic                 w_make_accept;
    logic                 w_break_accept;
    logic [NUM_KEYS-1:0]  w_key_bit;
    logic [NUM_KEYS-1:0]  w_mask_next;
    logic [KEY_IDX_W-1:0] w_last_next;
    logic [PERIOD_W-1:0]  w_lut_period;
    logic [PERIOD_W-1:0]  w_period_next;

    assign w_lookup = lookup_scancode(i_byte_data);

    // Decoder state register; reset drops any half-received prefix.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Prefix decoding: panic clear wins, then bytes, then prefix abandonment.
    always_comb begin
        w_next_state = r_state;
        w_make       = 1'b0;
        w_break      = 1'b0;
        if (i_all_off) begin
            w_next_state = ST_IDLE;
        end else if (i_byte_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_byte_data == SC_BREAK) begin
                        w_next_state = ST_BRK;
                    end else if (i_byte_data == SC_EXT) begin
                        w_next_state = ST_EXT;
                    end else begin
                        w_make = w_lookup.hit;
                    end
                end
                ST_BRK: begin
                    w_next_state = ST_IDLE;
                    w_break      = w_lookup.hit;
                end
                ST_EXT: begin
                    w_next_state = (i_byte_data == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end else if (r_state != ST_IDLE && r_timer == TIMER_LAST) begin
            w_next_state = ST_IDLE;
        end
    end

    // Prefix age counter: runs only while a prefix is pending and no byte arrives.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_timer <= '0;
        end else if (i_all_off || i_byte_valid || w_next_state == ST_IDLE) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TW'(1);
        end
    end

`ifdef KNT_TYPEMATIC_FILTER_EN
    assign w_make_accept = w_make && !r_key_mask[w_lookup.idx];
`else
    assign w_make_accept = w_make;
`endif
    assign w_break_accept = w_break && r_key_mask[w_lookup.idx];

    // Next held-key bitmap and the key whose pitch should sound.
    always_comb begin
        w_key_bit              = '0;
        w_key_bit[w_lookup.idx] = 1'b1;
        w_mask_next            = r_key_mask;
        if (w_make_accept) w_mask_next = r_key_mask | w_key_bit;
        if (w_break_accept) w_mask_next = r_key_mask & ~w_key_bit;
        w_last_next = r_last_key;
        if (w_make_accept) begin
            w_last_next = w_lookup.idx;
        end else if (!w_mask_next[r_last_key]) begin
            w_last_next = lowest_held(w_mask_next);
        end
    end

    note_period_lut u_lut (
        .i_key_idx (w_last_next),
        .o_period  (w_lut_period)
    );

    assign w_period_next = (w_mask_next == '0) ? '0 : w_lut_period;

    // Registered outputs; pulses are one cycle wide and mutually exclusive.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_key_mask    <= '0;
            r_last_key    <= '0;
            r_note_period <= '0;
            r_note_on     <= 1'b0;
            r_note_off    <= 1'b0;
        end else if (i_all_off) begin
            r_key_mask    <= '0;
            r_last_key    <= '0;
            r_note_period <= '0;
            r_note_on     <= 1'b0;
            r_note_off    <= 1'b0;
        end else begin
            r_key_mask    <= w_mask_next;
            r_last_key    <= w_last_next;
            r_note_period <= w_period_next;
            r_note_on     <= w_make_accept;
            r_note_off    <= w_break_accept;
        end
    end

    assign o_key_mask    = r_key_mask;
    assign o_note_period = r_note_period;
    assign o_note_on     = r_note_on;
    assign o_note_off    = r_note_off;

endmodule

// File: tb/tb_keyboard_note_tracker.sv
// Testbench for keyboard_note_tracker: directed scenarios with literal
// expectations plus randomized scancode traffic checked every cycle against
// a behavioural keyboard model. Honours KNT_TYPEMATIC_FILTER_EN.
module tb_keyboard_note_tracker;

    localparam int TIMEOUT = 8;
`ifdef KNT_TYPEMATIC_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        all_off = 1'b0;
    logic [7:0]  key_mask;
    logic [19:0] note_period;
    logic        note_on;
    logic        note_off;

    int nChecks = 0;
    int nFails  = 0;

    logic [7:0] codeTab[8]   = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42};
    int         periodTab[8] = '{191109, 170265, 151685, 143172, 127550, 113636, 101238, 95556};

    bit  held[8];
    int  lastKey = -1;
    bit  sawBrk = 0;
    bit  sawExt = 0;
    longint cycleNo = 0;
    longint prefixCycle = 0;
    logic [7:0]  expMask = '0;
    logic [19:0] expPeriod = '0;
    logic        expOn = 1'b0;
    logic        expOff = 1'b0;

    keyboard_note_tracker #(.PREFIX_TIMEOUT(TIMEOUT)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_byte_valid  (byte_valid),
        .i_byte_data   (byte_data),
        .i_all_off     (all_off),
        .o_key_mask    (key_mask),
        .o_note_period (note_period),
        .o_note_on     (note_on),
        .o_note_off    (note_off)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int findKey(input logic [7:0] code);
        for (int i = 0; i < 8; i++) begin
            if (codeTab[i] == code) return i;
        end
        return -1;
    endfunction

    // Behavioural keyboard model, advanced on every rising edge.
    always @(posedge clk) begin
        int k;
        cycleNo++;
        if (!rst_n || all_off) begin
            foreach (held[i]) held[i] = 0;
            lastKey = -1;
            sawBrk  = 0;
            sawExt  = 0;
            expOn   = 0;
            expOff  = 0;
        end else begin
            expOn  = 0;
            expOff = 0;
            if (byte_valid) begin
                if ((sawBrk || sawExt) && (cycleNo - prefixCycle - 1 >= TIMEOUT)) begin
                    sawBrk = 0;
                    sawExt = 0;
                end
                k = findKey(byte_data);
                if (!sawBrk && !sawExt) begin
                    if (byte_data == 8'hF0) begin
                        sawBrk = 1; prefixCycle = cycleNo;
                    end else if (byte_data == 8'hE0) begin
                        sawExt = 1; prefixCycle = cycleNo;
                    end else if (k >= 0) begin
                        if (!(FILTER && held[k])) begin
                            held[k] = 1; lastKey = k; expOn = 1;
                        end
                    end
                end else if (sawExt && !sawBrk) begin
                    if (byte_data == 8'hF0) begin
                        sawBrk = 1; prefixCycle = cycleNo;
                    end else begin
                        sawExt = 0;
                    end
                end else if (sawBrk && !sawExt) begin
                    if (k >= 0 && held[k]) begin
                        held[k] = 0; expOff = 1;
                    end
                    sawBrk = 0;
                end else begin
                    sawBrk = 0;
                    sawExt = 0;
                end
            end
            if (lastKey < 0 || !held[lastKey]) begin
                lastKey = -1;
                for (int i = 7; i >= 0; i--) if (held[i]) lastKey = i;
            end
        end
        expMask = '0;
        foreach (held[i]) if (held[i]) expMask = expMask + 8'(1 << i);
        expPeriod = (lastKey >= 0) ? 20'(periodTab[lastKey]) : 20'd0;
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        checkOutput("modelKeyMask", 32'(key_mask), 32'(expMask));
        checkOutput("modelNotePeriod", 32'(note_period), 32'(expPeriod));
        checkOutput("modelNoteOn", 32'(note_on), 32'(expOn));
        checkOutput("modelNoteOff", 32'(note_off), 32'(expOff));
        checkOutput("onOffExclusive", 32'(note_on & note_off), 32'd0);
    end

    // One clock of input; returns just after the following falling edge.
    task automatic applyStimulus(input logic v, input logic [7:0] b, input logic off);
        byte_valid = v;
        byte_data  = b;
        all_off    = off;
        @(negedge clk);
        #1;
        byte_valid = 1'b0;
        all_off    = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        logic [7:0] b;
        int r;
        $display("[TB] start, typematic filter = %0d", FILTER);
        repeat (3) @(negedge clk);
        checkOutput("rstMask", 32'(key_mask), 32'd0);
        checkOutput("rstPeriod", 32'(note_period), 32'd0);
        checkOutput("rstOn", 32'(note_on), 32'd0);
        checkOutput("rstOff", 32'(note_off), 32'd0);
        #1 rst_n = 1'b1;
        idleCycles(2);

        applyStimulus(1'b1, 8'h1C, 1'b0);
        checkOutput("c4Mask", 32'(key_mask), 32'h01);
        checkOutput("c4Period", 32'(note_period), 32'd191109);
        checkOutput("c4On", 32'(note_on), 32'd1);

        applyStimulus(1'b1, 8'h34, 1'b0);
        checkOutput("g4Mask", 32'(key_mask), 32'h11);
        checkOutput("g4Period", 32'(note_period), 32'd127550);
        applyStimulus(1'b1, 8'hF0, 1'b0);
        applyStimulus(1'b1, 8'h34, 1'b0);
        checkOutput("g4RelMask", 32'(key_mask), 32'h01);
        checkOutput("g4RelPeriod", 32'(note_period), 32'd191109);
        checkOutput("g4RelOff", 32'(note_off), 32'd1);
        checkOutput("g4RelOn", 32'(note_on), 32'd0);
        idleCycles(1);
        checkOutput("offPulseWidth", 32'(note_off), 32'd0);

        applyStimulus(1'b1, 8'hE0, 1'b0);
        applyStimulus(1'b1, 8'h1C, 1'b0);
        checkOutput("extMakeOn", 32'(note_on), 32'd0);
        applyStimulus(1'b1, 8'hE0, 1'b0);
        applyStimulus(1'b1, 8'hF0, 1'b0);
        applyStimulus(1'b1, 8'h1C, 1'b0);
        checkOutput("extBrkMask", 32'(key_mask), 32'h01);
        checkOutput("extBrkPeriod", 32'(note_period), 32'd191109);
        checkOutput("extBrkOff", 32'(note_off), 32'd0);

        applyStimulus(1'b1, 8'hF0, 1'b0);
        idleCycles(TIMEOUT + 1);
        applyStimulus(1'b1, 8'h1B, 1'b0);
        checkOutput("toMask", 32'(key_mask), 32'h03);
        checkOutput("toPeriod", 32'(note_period), 32'd170265);
        checkOutput("toOn", 32'(note_on), 32'd1);

        applyStimulus(1'b1, 8'h33, 1'b0);
        checkOutput("a4FirstOn", 32'(note_on), 32'd1);
        applyStimulus(1'b1, 8'h33, 1'b0);
        checkOutput("a4RepeatOn", 32'(note_on), FILTER ? 32'd0 : 32'd1);
        checkOutput("a4Period", 32'(note_period), 32'd113636);

        applyStimulus(1'b1, 8'hF0, 1'b1);
        checkOutput("panicMask", 32'(key_mask), 32'd0);
        checkOutput("panicPeriod", 32'(note_period), 32'd0);
        checkOutput("panicOff", 32'(note_off), 32'd0);
        applyStimulus(1'b1, 8'h1C, 1'b0);
        checkOutput("postPanicMask", 32'(key_mask), 32'h01);
        checkOutput("postPanicOn", 32'(note_on), 32'd1);

        applyStimulus(1'b1, 8'hF0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("asyncRstMask", 32'(key_mask), 32'd0);
        checkOutput("asyncRstPeriod", 32'(note_period), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(1'b1, 8'h34, 1'b0);
        checkOutput("rstPrefixMask", 32'(key_mask), 32'h10);
        checkOutput("rstPrefixPeriod", 32'(note_period), 32'd127550);
        checkOutput("rstPrefixOn", 32'(note_on), 32'd1);

        for (int it = 0; it < 1500; it++) begin
            r = $urandom_range(0, 9);
            if (r == 5)      b = 8'hF0;
            else if (r == 6) b = 8'hE0;
            else if (r == 7) b = 8'($urandom);
            else             b = codeTab[$urandom_range(0, 7)];
            applyStimulus(1'b1, b, ($urandom_range(0, 39) == 0));
            r = $urandom_range(0, 19);
            if (r == 0)      idleCycles($urandom_range(TIMEOUT - 1, TIMEOUT + 1));
            else if (r == 1) applyStimulus(1'b0, 8'h00, 1'b1);
            else if (r == 2 && $urandom_range(0, 9) == 0) begin
                rst_n = 1'b0;
                idleCycles(1);
                rst_n = 1'b1;
            end else         idleCycles($urandom_range(0, 3));
        end

        idleCycles(2);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
